// File: rtl/frame_sync_if.sv
// -----------------------------------------------------------------------------
// frame_sync_if
// Groups the serial input and frame output signals of frame_sync_ctrl.
//   ser_i       : serial bit from iq_comb (qualified by sync_flag)
//   sync_flag   : one new serial bit per high cycle
//   clear_err   : synchronous clear of err_cnt
//   locked      : high while the synchroniser is in LOCK
//   frame_valid : one-cycle pulse, frame_data updated in the same cycle
//   frame_data  : last accepted 40-bit frame
//   frame_err   : one-cycle pulse on a rejected boundary frame in LOCK
//   err_cnt     : saturating count of frame_err pulses
// master = bit source / frame consumer, slave = frame_sync_ctrl.
// -----------------------------------------------------------------------------
interface frame_sync_if;
    logic        ser_i;
    logic        sync_flag;
    logic        clear_err;
    logic        locked;
    logic        frame_valid;
    logic [39:0] frame_data;
    logic        frame_err;
    logic [15:0] err_cnt;

    modport master (
        output ser_i, sync_flag, clear_err,
        input  locked, frame_valid, frame_data, frame_err, err_cnt
    );

    modport slave (
        input  ser_i, sync_flag, clear_err,
        output locked, frame_valid, frame_data, frame_err, err_cnt
    );
endinterface

// File: rtl/frame_sync_ctrl.sv
// -----------------------------------------------------------------------------
// frame_sync_ctrl
// Frame synchroniser and lock controller for the QPSK receive path.
// Hunts bit by bit for a 40-bit frame {header, 3 data bytes, checksum},
// confirms the alignment over CONFIRM_N consecutive frames, then checks only
// at 40-bit boundaries while locked. MISS_N consecutive bad boundary frames
// drop the controller back to hunting.
// Ports:
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   bus   : frame_sync_if.slave (ser_i, sync_flag, clear_err in;
//           locked, frame_valid, frame_data, frame_err, err_cnt out)
// -----------------------------------------------------------------------------
module frame_sync_ctrl #(
    parameter logic [7:0] HEADER    = 8'b1100_1100,
    parameter int         CONFIRM_N = 2,
    parameter int         MISS_N    = 3
) (
    input  logic           clk,
    input  logic           rst_n,
    frame_sync_if.slave    bus
);

    typedef enum logic [1:0] {SEARCH, VERIFY, LOCK} state_t;

    localparam logic [7:0] CONFIRM_L = 8'(CONFIRM_N);
    localparam logic [7:0] MISS_L    = 8'(MISS_N);

    state_t      r_state;
    logic [39:0] r_sr;
    logic        r_new_bit;
    logic [5:0]  r_bit_cnt;
    logic [7:0]  r_good_cnt;
    logic [7:0]  r_miss_cnt;
    logic        r_locked;
    logic        r_frame_valid;
    logic [39:0] r_frame_data;
    logic        r_frame_err;
    logic [15:0] r_err_cnt;

    logic        w_ok;
    logic        w_boundary;
    logic        w_err_inc;
    logic [7:0]  w_good_nxt;
    logic [7:0]  w_miss_nxt;

    // Header match plus 8-bit modular checksum over header and data bytes.
    function automatic logic frame_ok(input logic [39:0] f);
        logic [7:0] sum;
        sum = f[39:32] + f[31:24] + f[23:16] + f[15:8];
        return (f[39:32] == HEADER) && (sum == f[7:0]);
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign w_ok       = frame_ok(r_sr);
    assign w_boundary = r_new_bit && (r_bit_cnt == 6'd39);
    assign w_err_inc  = (r_state == LOCK) && w_boundary && !w_ok;
    assign w_good_nxt = r_good_cnt + 8'd1;
    assign w_miss_nxt = r_miss_cnt + 8'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= SEARCH;
            r_sr          <= '0;
            r_new_bit     <= 1'b0;
            r_bit_cnt     <= '0;
            r_good_cnt    <= '0;
            r_miss_cnt    <= '0;
            r_locked      <= 1'b0;
            r_frame_valid <= 1'b0;
            r_frame_data  <= '0;
            r_frame_err   <= 1'b0;
            r_err_cnt     <= '0;
        end else begin
            r_frame_valid <= 1'b0;
            r_frame_err   <= 1'b0;

            // First transmitted bit walks down to bit 0 after 40 shifts.
            if (bus.sync_flag)
                r_sr <= {bus.ser_i, r_sr[39:1]};
            r_new_bit <= bus.sync_flag;

            if (r_new_bit)
                r_bit_cnt <= (r_bit_cnt == 6'd39) ? 6'd0 : r_bit_cnt + 6'd1;

            // Clear beats a simultaneous increment.
            if (bus.clear_err)
                r_err_cnt <= '0;
            else if (w_err_inc)
                r_err_cnt <= sat_inc16(r_err_cnt);

            unique case (r_state)
                SEARCH: begin
                    if (r_new_bit && w_ok) begin
                        // Realign the boundary counter to this frame.
                        r_bit_cnt <= '0;
                        if (CONFIRM_N <= 1) begin
                            r_state       <= LOCK;
                            r_locked      <= 1'b1;
                            r_frame_valid <= 1'b1;
                            r_frame_data  <= r_sr;
                            r_miss_cnt    <= '0;
                            r_good_cnt    <= '0;
                        end else begin
                            r_state    <= VERIFY;
                            r_good_cnt <= 8'd1;
                        end
                    end
                end
                VERIFY: begin
                    if (w_boundary) begin
                        if (w_ok) begin
                            if (w_good_nxt == CONFIRM_L) begin
                                r_state       <= LOCK;
                                r_locked      <= 1'b1;
                                r_frame_valid <= 1'b1;
                                r_frame_data  <= r_sr;
                                r_miss_cnt    <= '0;
                                r_good_cnt    <= '0;
                            end else begin
                                r_good_cnt <= w_good_nxt;
                            end
                        end else begin
                            r_state    <= SEARCH;
                            r_good_cnt <= '0;
                        end
                    end
                end
                LOCK: begin
                    if (w_boundary) begin
                        if (w_ok) begin
                            r_frame_valid <= 1'b1;
                            r_frame_data  <= r_sr;
                            r_miss_cnt    <= '0;
                        end else begin
                            r_frame_err <= 1'b1;
                            if (w_miss_nxt == MISS_L) begin
                                // locked drops together with the last frame_err.
                                r_state    <= SEARCH;
                                r_locked   <= 1'b0;
                                r_miss_cnt <= '0;
                            end else begin
                                r_miss_cnt <= w_miss_nxt;
                            end
                        end
                    end
                end
                default: begin
                    r_state <= SEARCH;
                end
            endcase
        end
    end

    assign bus.locked      = r_locked;
    assign bus.frame_valid = r_frame_valid;
    assign bus.frame_data  = r_frame_data;
    assign bus.frame_err   = r_frame_err;
    assign bus.err_cnt     = r_err_cnt;

endmodule

// File: tb/tb_frame_sync_ctrl.sv
// -----------------------------------------------------------------------------
// tb_frame_sync_ctrl
// Directed bench for frame_sync_ctrl with CONFIRM_N=2, MISS_N=3.
// Frames are shifted in bit 0 first; outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_frame_sync_ctrl;

    localparam logic [39:0] F_GOOD  = 40'hCC010203D2;
    localparam logic [39:0] G_GOOD  = 40'hCC1020302C;
    localparam logic [39:0] B_BAD   = 40'hCC01020300;

    logic clk = 1'b0;
    logic rst_n;
    int   tests = 0;
    int   fails = 0;
    int   fv_total = 0;
    int   fe_total = 0;

    always #5 clk = ~clk;

    frame_sync_if bus ();

    frame_sync_ctrl #(
        .HEADER    (8'hCC),
        .CONFIRM_N (2),
        .MISS_N    (3)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always @(negedge clk) begin
        if (rst_n && bus.frame_valid) fv_total <= fv_total + 1;
        if (rst_n && bus.frame_err)   fe_total <= fe_total + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout want finish");
        $fatal(1, "watchdog");
    end

    function automatic bit model_ok(input logic [39:0] w);
        logic [7:0] s;
        s = 8'h00;
        for (int k = 1; k < 5; k++) s = s + w[8*k +: 8];
        return (w[39:32] == 8'hCC) && (s == w[7:0]);
    endfunction

    task automatic do_reset();
        rst_n         = 1'b0;
        bus.ser_i     = 1'b0;
        bus.sync_flag = 1'b0;
        bus.clear_err = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // One qualified bit; sync_flag period is 2 + gap cycles.
    task automatic send_bit(input logic b, input int gap);
        @(negedge clk);
        bus.ser_i     = b;
        bus.sync_flag = 1'b1;
        @(negedge clk);
        bus.sync_flag = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic send_frame(input logic [39:0] f);
        for (int i = 0; i < 40; i++) send_bit(f[i], 0);
    endtask

    task automatic lock_up();
        do_reset();
        send_frame(F_GOOD);
        send_frame(F_GOOD);
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n         = 1'b0;
        bus.ser_i     = 1'b1;
        bus.sync_flag = 1'b1;
        bus.clear_err = 1'b0;
        repeat (2) @(negedge clk);
        tests++; if (bus.locked !== 1'b0) begin fails++; $display("FAIL reset_locked: got %b want 0", bus.locked); end
        tests++; if (bus.frame_valid !== 1'b0) begin fails++; $display("FAIL reset_fv: got %b want 0", bus.frame_valid); end
        tests++; if (bus.frame_data !== 40'h0) begin fails++; $display("FAIL reset_fd: got %h want 0", bus.frame_data); end
        tests++; if (bus.frame_err !== 1'b0) begin fails++; $display("FAIL reset_fe: got %b want 0", bus.frame_err); end
        tests++; if (bus.err_cnt !== 16'h0) begin fails++; $display("FAIL reset_err: got %h want 0", bus.err_cnt); end
        bus.sync_flag = 1'b0;
    endtask

    task automatic test_random();
        logic [39:0] m;
        logic [39:0] mt;
        logic        b;
        int          v0;
        int          e0;
        do_reset();
        m  = '0;
        v0 = fv_total;
        e0 = fe_total;
        for (int i = 0; i < 200; i++) begin
            b  = logic'($urandom_range(0, 1));
            mt = {b, m[39:1]};
            // The newest bit lands in the header MSB, so flipping it kills any match.
            if (model_ok(mt)) begin
                b  = ~b;
                mt = {b, m[39:1]};
            end
            m = mt;
            send_bit(b, 2);
        end
        repeat (4) @(negedge clk);
        tests++; if (fv_total - v0 != 0) begin fails++; $display("FAIL random_fv: got %0d pulses want 0", fv_total - v0); end
        tests++; if (fe_total - e0 != 0) begin fails++; $display("FAIL random_fe: got %0d pulses want 0", fe_total - e0); end
        tests++; if (bus.locked !== 1'b0) begin fails++; $display("FAIL random_locked: got %b want 0", bus.locked); end
        tests++; if (bus.err_cnt !== 16'h0) begin fails++; $display("FAIL random_err: got %h want 0", bus.err_cnt); end
    endtask

    task automatic test_acquire();
        int v0;
        do_reset();
        v0 = fv_total;
        send_frame(F_GOOD);
        repeat (3) @(negedge clk);
        tests++; if (fv_total != v0) begin fails++; $display("FAIL acq_first_fv: got %0d pulses want 0", fv_total - v0); end
        tests++; if (bus.locked !== 1'b0) begin fails++; $display("FAIL acq_first_locked: got %b want 0", bus.locked); end
        send_frame(F_GOOD);
        // One cycle after the last sync_flag: not yet.
        tests++; if (bus.frame_valid !== 1'b0) begin fails++; $display("FAIL acq_early_fv: got %b want 0", bus.frame_valid); end
        @(negedge clk);
        tests++; if (bus.frame_valid !== 1'b1) begin fails++; $display("FAIL acq_fv: got %b want 1", bus.frame_valid); end
        tests++; if (bus.frame_data !== F_GOOD) begin fails++; $display("FAIL acq_fd: got %h want %h", bus.frame_data, F_GOOD); end
        tests++; if (bus.locked !== 1'b1) begin fails++; $display("FAIL acq_locked: got %b want 1", bus.locked); end
        @(negedge clk);
        tests++; if (bus.frame_valid !== 1'b0) begin fails++; $display("FAIL acq_fv_pulse: got %b want 0", bus.frame_valid); end
    endtask

    task automatic test_single_miss();
        lock_up();
        send_frame(B_BAD);
        @(negedge clk);
        tests++; if (bus.frame_err !== 1'b1) begin fails++; $display("FAIL miss1_fe: got %b want 1", bus.frame_err); end
        tests++; if (bus.err_cnt !== 16'd1) begin fails++; $display("FAIL miss1_err: got %0d want 1", bus.err_cnt); end
        tests++; if (bus.locked !== 1'b1) begin fails++; $display("FAIL miss1_locked: got %b want 1", bus.locked); end
        tests++; if (bus.frame_data !== F_GOOD) begin fails++; $display("FAIL miss1_fd_hold: got %h want %h", bus.frame_data, F_GOOD); end
        send_frame(G_GOOD);
        @(negedge clk);
        tests++; if (bus.frame_valid !== 1'b1) begin fails++; $display("FAIL miss1_fv: got %b want 1", bus.frame_valid); end
        tests++; if (bus.frame_data !== G_GOOD) begin fails++; $display("FAIL miss1_fd: got %h want %h", bus.frame_data, G_GOOD); end
        // Two more misses stay locked only if the good frame reset miss_cnt.
        send_frame(B_BAD);
        send_frame(B_BAD);
        repeat (2) @(negedge clk);
        tests++; if (bus.locked !== 1'b1) begin fails++; $display("FAIL miss1_reset_cnt: got locked=%b want 1", bus.locked); end
        tests++; if (bus.err_cnt !== 16'd3) begin fails++; $display("FAIL miss1_err3: got %0d want 3", bus.err_cnt); end
    endtask

    task automatic test_three_miss();
        int e0;
        int v0;
        lock_up();
        e0 = fe_total;
        send_frame(B_BAD);
        @(negedge clk);
        tests++; if (bus.locked !== 1'b1) begin fails++; $display("FAIL miss3_locked1: got %b want 1", bus.locked); end
        send_frame(B_BAD);
        send_frame(B_BAD);
        @(negedge clk);
        tests++; if (bus.frame_err !== 1'b1) begin fails++; $display("FAIL miss3_fe: got %b want 1", bus.frame_err); end
        tests++; if (bus.locked !== 1'b0) begin fails++; $display("FAIL miss3_unlock: got %b want 0", bus.locked); end
        tests++; if (bus.err_cnt !== 16'd3) begin fails++; $display("FAIL miss3_err: got %0d want 3", bus.err_cnt); end
        repeat (2) @(negedge clk);
        tests++; if (fe_total - e0 != 3) begin fails++; $display("FAIL miss3_fe_count: got %0d want 3", fe_total - e0); end
        v0 = fv_total;
        send_frame(F_GOOD);
        repeat (3) @(negedge clk);
        tests++; if (fv_total != v0) begin fails++; $display("FAIL miss3_relock_early: got %0d pulses want 0", fv_total - v0); end
        send_frame(F_GOOD);
        @(negedge clk);
        tests++; if (bus.frame_valid !== 1'b1 || bus.locked !== 1'b1) begin
            fails++; $display("FAIL miss3_relock: got fv=%b locked=%b want 1 1", bus.frame_valid, bus.locked);
        end
    endtask

    task automatic test_shift();
        int v0;
        do_reset();
        v0 = fv_total;
        send_frame(B_BAD);
        for (int i = 0; i < 5; i++) send_bit(1'b1, 0);
        send_frame(G_GOOD);
        repeat (3) @(negedge clk);
        tests++; if (fv_total != v0 || bus.locked !== 1'b0) begin
            fails++; $display("FAIL shift_verify: got pulses=%0d locked=%b want 0 0", fv_total - v0, bus.locked);
        end
        send_frame(G_GOOD);
        @(negedge clk);
        tests++; if (bus.frame_valid !== 1'b1) begin fails++; $display("FAIL shift_fv: got %b want 1", bus.frame_valid); end
        tests++; if (bus.frame_data !== G_GOOD) begin fails++; $display("FAIL shift_fd: got %h want %h", bus.frame_data, G_GOOD); end
        tests++; if (bus.locked !== 1'b1) begin fails++; $display("FAIL shift_locked: got %b want 1", bus.locked); end
    endtask

    task automatic test_clear_and_reset();
        int v0;
        lock_up();
        send_frame(B_BAD);
        send_frame(B_BAD);
        send_frame(G_GOOD);
        @(negedge clk);
        tests++; if (bus.err_cnt !== 16'd2) begin fails++; $display("FAIL clr_pre: got %0d want 2", bus.err_cnt); end
        send_frame(B_BAD);
        bus.clear_err = 1'b1;
        @(negedge clk);
        bus.clear_err = 1'b0;
        tests++; if (bus.frame_err !== 1'b1) begin fails++; $display("FAIL clr_fe: got %b want 1", bus.frame_err); end
        tests++; if (bus.err_cnt !== 16'd0) begin fails++; $display("FAIL clr_err: got %0d want 0", bus.err_cnt); end
        tests++; if (bus.locked !== 1'b1) begin fails++; $display("FAIL clr_locked: got %b want 1", bus.locked); end
        // Reset asynchronously in the middle of a frame.
        for (int i = 0; i < 20; i++) send_bit(F_GOOD[i], 0);
        rst_n = 1'b0;
        #1;
        tests++; if (bus.locked !== 1'b0) begin fails++; $display("FAIL rst_locked: got %b want 0", bus.locked); end
        tests++; if (bus.frame_data !== 40'h0) begin fails++; $display("FAIL rst_fd: got %h want 0", bus.frame_data); end
        tests++; if (bus.err_cnt !== 16'h0 || bus.frame_valid !== 1'b0 || bus.frame_err !== 1'b0) begin
            fails++; $display("FAIL rst_outs: got err=%h fv=%b fe=%b want 0 0 0", bus.err_cnt, bus.frame_valid, bus.frame_err);
        end
        @(negedge clk);
        rst_n = 1'b1;
        v0 = fv_total;
        send_frame(F_GOOD);
        repeat (3) @(negedge clk);
        tests++; if (fv_total != v0 || bus.locked !== 1'b0) begin
            fails++; $display("FAIL rst_relock_early: got pulses=%0d locked=%b want 0 0", fv_total - v0, bus.locked);
        end
        send_frame(F_GOOD);
        @(negedge clk);
        tests++; if (bus.frame_valid !== 1'b1 || bus.locked !== 1'b1 || bus.frame_data !== F_GOOD) begin
            fails++; $display("FAIL rst_relock: got fv=%b locked=%b fd=%h want 1 1 %h", bus.frame_valid, bus.locked, bus.frame_data, F_GOOD);
        end
    endtask

    initial begin
        test_reset();
        test_random();
        test_acquire();
        test_single_miss();
        test_three_miss();
        test_shift();
        test_clear_and_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
